// File: rtl/result_mem_writer.sv
// Write-side producer for one vector result memory: turns a stream of ALU result rows
// into write strobes, row addresses, next-row requests and an end-of-pass pulse.
module result_mem_writer #(
   parameter int no_of_units   = 8,
   parameter int element_width = 32
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   start,
   input  logic                                   finish_alu,
   input  logic [31:0]                            total,
   input  logic                                   alu_valid,
   input  logic [no_of_units*element_width-1:0]   alu_data,
   output logic                                   result_mem_we,
   output logic [31:0]                            result_mem_counter,
   output logic [no_of_units*element_width-1:0]   result_mem_data,
   output logic                                   read_again,
   output logic                                   finish,
   output logic                                   busy,
   output logic                                   err,
   output logic [1:0]                             state_dbg
);

   // Handshake: there is no back-pressure. A row is taken in the cycle alu_valid=1
   // while ACTIVE (and finish_alu=0); its write appears on the next cycle with
   // result_mem_we=1. read_again asks the operand side for the next row.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] rows;
   logic [31:0] total_rows;
   logic [31:0] accepted;
   logic        take_beat;
   logic        more_rows;

   assign total_rows = total / 32'(no_of_units);
   assign busy       = (state == ACTIVE);
   assign state_dbg  = state;

   // The counter register still shows the previous write's address while that
   // write is on the bus, so rows accepted so far includes it.
   assign accepted   = result_mem_we ? (result_mem_counter + 32'd1) : result_mem_counter;
   assign more_rows  = (accepted + 32'd1) < rows;

   always_comb begin
      state_next = state;
      take_beat  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = (total_rows == 32'd0) ? DONE : ACTIVE;
            end
         end
         ACTIVE: begin
            if (alu_valid) begin
               take_beat = 1'b1;
               if (!more_rows) begin
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      if (finish_alu) begin
         state_next = IDLE;
         take_beat  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state              <= IDLE;
         rows               <= 32'd0;
         result_mem_we      <= 1'b0;
         result_mem_counter <= 32'd0;
         result_mem_data    <= '0;
         read_again         <= 1'b0;
         finish             <= 1'b0;
         err                <= 1'b0;
      end else begin
         state         <= state_next;
         result_mem_we <= take_beat;
         read_again    <= take_beat && more_rows;
         finish        <= (state == DONE) && !finish_alu;
         if (take_beat) begin
            result_mem_data <= alu_data;
         end
         if (alu_valid && (state != ACTIVE)) begin
            err <= 1'b1;
         end
         // Address advances the cycle after each write; wrap to 0 only after the last row.
         if (finish_alu) begin
            result_mem_counter <= 32'd0;
         end else if ((state == IDLE) && start) begin
            rows               <= total_rows;
            result_mem_counter <= 32'd0;
         end else if (result_mem_we) begin
            result_mem_counter <= ((result_mem_counter + 32'd1) == rows) ? 32'd0
                                                                        : (result_mem_counter + 32'd1);
         end
      end
   end

endmodule
